// File: rtl/data_memory_bist.sv
// March-style self-test for data_memory: ascending write, ascending read/invert, descending read.
// Define BIST_STOP_ON_FAIL_EN to halt at the first mismatch and discard in-flight compares.

module data_memory_bist #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [15:0] SEED         = 16'hA5A5,
    parameter int unsigned ERR_WIDTH    = 8
) (
    input  logic                  mclk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_val,
    output logic                  mem_get,
    output logic                  mem_set,
    input  logic [DATA_WIDTH-1:0] mem_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [15:0]           disp_val
);

    typedef enum logic [2:0] {StIdle, StWUp, StRwUp, StRDown, StDrain, StDone} state_e;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] exp_data;
        logic [ADDR_WIDTH-1:0] addr;
    } cmp_t;

    localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [2:0]            LastDrain = 3'(READ_LATENCY - 1);

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
        return DATA_WIDTH'(a) ^ DATA_WIDTH'(SEED);
    endfunction

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  phase_q, phase_d;
    logic [2:0]            drain_q, drain_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;

    logic [ADDR_WIDTH-1:0] mem_addr_d, fail_addr_d;
    logic [DATA_WIDTH-1:0] mem_val_d;
    logic                  mem_get_d, mem_set_d, busy_d, done_d, pass_d;
    logic [ERR_WIDTH-1:0]  err_d;
    logic [15:0]           disp_d;
    logic [7:0]            err8, fa8;

    cmp_t cur, cmp;
    logic mismatch, flush;

    // The tuple describing this cycle's access; delayed to line up with mem_out.
    assign cur      = '{valid: mem_get, exp_data: exp_q, addr: mem_addr};
    assign mismatch = cmp.valid && (mem_out != cmp.exp_data);

`ifdef BIST_STOP_ON_FAIL_EN
    assign flush = mismatch;
`else
    assign flush = 1'b0;
`endif

    generate
        if (READ_LATENCY == 0) begin : g_no_pipe
            assign cmp = cur;
        end else begin : g_pipe
            cmp_t pipe_q [READ_LATENCY];

            always_ff @(posedge mclk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
                end else if (flush) begin
                    for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= cur;
                    for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign cmp = pipe_q[READ_LATENCY-1];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        drain_d     = drain_q;
        err_d       = err_count;
        fail_addr_d = fail_addr;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StWUp;
                    addr_d      = '0;
                    phase_d     = 1'b0;
                    err_d       = '0;
                    fail_addr_d = '0;
                end
            end
            StWUp: begin
                if (addr_q == LastAddr) begin
                    state_d = StRwUp;
                    addr_d  = '0;
                    phase_d = 1'b0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StRwUp: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (addr_q == LastAddr) begin
                        state_d = StRDown;
                        addr_d  = LastAddr;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            StRDown: begin
                if (addr_q == '0) begin
                    drain_d = '0;
                    state_d = (READ_LATENCY == 0) ? StDone : StDrain;
                end else begin
                    addr_d = addr_q - 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == LastDrain) state_d = StDone;
                else                      drain_d = drain_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (mismatch) begin
            if (!(&err_count)) err_d = err_count + 1'b1;
            if (err_count == '0) fail_addr_d = cmp.addr;
`ifdef BIST_STOP_ON_FAIL_EN
            state_d = StDone;
`endif
        end

        // Outputs are registered, so decode them from the next state.
        mem_get_d  = 1'b0;
        mem_set_d  = 1'b0;
        mem_val_d  = '0;
        mem_addr_d = '0;
        exp_d      = '0;
        case (state_d)
            StWUp: begin
                mem_set_d  = 1'b1;
                mem_addr_d = addr_d;
                mem_val_d  = pattern(addr_d);
            end
            StRwUp: begin
                mem_addr_d = addr_d;
                if (!phase_d) begin
                    mem_get_d = 1'b1;
                    exp_d     = pattern(addr_d);
                end else begin
                    mem_set_d = 1'b1;
                    mem_val_d = ~pattern(addr_d);
                end
            end
            StRDown: begin
                mem_get_d  = 1'b1;
                mem_addr_d = addr_d;
                exp_d      = ~pattern(addr_d);
            end
            default: ;
        endcase

        busy_d = (state_d == StWUp) || (state_d == StRwUp) ||
                 (state_d == StRDown) || (state_d == StDrain);
        done_d = (state_d == StDone);
        pass_d = done_d && (err_d == '0);
        err8   = 8'(err_d);
        fa8    = 8'(fail_addr_d);
        disp_d = (done_d && !pass_d) ? {fa8, err8} : 16'h0000;
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            phase_q   <= 1'b0;
            drain_q   <= '0;
            exp_q     <= '0;
            mem_addr  <= '0;
            mem_val   <= '0;
            mem_get   <= 1'b0;
            mem_set   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            disp_val  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            phase_q   <= phase_d;
            drain_q   <= drain_d;
            exp_q     <= exp_d;
            mem_addr  <= mem_addr_d;
            mem_val   <= mem_val_d;
            mem_get   <= mem_get_d;
            mem_set   <= mem_set_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            err_count <= err_d;
            fail_addr <= fail_addr_d;
            disp_val  <= disp_d;
        end
    end

endmodule

// File: tb/tb_data_memory_bist.sv
// Scoreboard bench for data_memory_bist: two instances (default and DEPTH=16/latency 3/ERR_WIDTH=2)
// driving fault-injectable memory models; a monitor per instance checks each completed run.

module tb_data_memory_bist;

    typedef struct {
        int err;
        int fa;
        int pass;
        int disp;
        int busy;
        int acc;
    } exp_t;

`ifdef BIST_STOP_ON_FAIL_EN
    localparam int StuckErr = 1, StuckBusy = 16, StuckAcc = 16, StuckDisp = 16'h0301;
    localparam int AliasErr = 1, AliasBusy = 10, AliasAcc = 10, AliasDisp = 16'h0001;
    localparam int LatErr = 1, LatBusy = 20, LatAcc = 20, LatDisp = 16'h0001;
`else
    localparam int StuckErr = 1, StuckBusy = 33, StuckAcc = 32, StuckDisp = 16'h0301;
    localparam int AliasErr = 12, AliasBusy = 33, AliasAcc = 32, AliasDisp = 16'h000C;
    localparam int LatErr = 3, LatBusy = 67, LatAcc = 64, LatDisp = 16'h0003;
`endif

    logic mclk = 1'b0;
    logic rst  = 1'b1;
    logic start_m = 1'b0;
    logic start_l = 1'b0;

    logic [15:0] addr_m, val_m, out_m, fa_m, disp_m;
    logic        get_m, set_m, busy_m, done_m, pass_m;
    logic [7:0]  err_m;
    logic [15:0] addr_l, val_l, out_l, fa_l, disp_l;
    logic        get_l, set_l, busy_l, done_l, pass_l;
    logic [1:0]  err_l;

    int n_total = 0;
    int n_bad   = 0;
    int fault_m = 0;
    int fault_l = 0;
    exp_t q_m[$];
    exp_t q_l[$];

    logic [15:0] mem_m [32];
    logic [15:0] mem_l [32];
    logic [15:0] rd_m, rd1, rd2, rd3;

    always #5 mclk = ~mclk;

    data_memory_bist u_main (
        .mclk(mclk), .rst(rst), .start(start_m),
        .mem_addr(addr_m), .mem_val(val_m), .mem_get(get_m), .mem_set(set_m), .mem_out(out_m),
        .busy(busy_m), .done(done_m), .pass(pass_m), .err_count(err_m), .fail_addr(fa_m),
        .disp_val(disp_m)
    );

    data_memory_bist #(.DEPTH(16), .READ_LATENCY(3), .ERR_WIDTH(2)) u_lat (
        .mclk(mclk), .rst(rst), .start(start_l),
        .mem_addr(addr_l), .mem_val(val_l), .mem_get(get_l), .mem_set(set_l), .mem_out(out_l),
        .busy(busy_l), .done(done_l), .pass(pass_l), .err_count(err_l), .fail_addr(fa_l),
        .disp_val(disp_l)
    );

    // Fault 2: address bit 2 ignored. Fault 1: bit 0 of cell 3 reads as 1.
    function automatic logic [4:0] map_addr(input logic [15:0] a, input int f);
        return (f == 2) ? (a[4:0] & 5'b11011) : a[4:0];
    endfunction

    function automatic logic [15:0] rd_fault(input logic [15:0] d, input logic [4:0] ix,
                                             input int f);
        return (f == 1 && ix == 5'd3) ? (d | 16'h0001) : d;
    endfunction

    always @(posedge mclk) begin
        if (set_m) mem_m[map_addr(addr_m, fault_m)] <= val_m;
        rd_m <= rd_fault(mem_m[map_addr(addr_m, fault_m)], map_addr(addr_m, fault_m), fault_m);
        if (set_l) mem_l[map_addr(addr_l, fault_l)] <= val_l;
        rd1 <= rd_fault(mem_l[map_addr(addr_l, fault_l)], map_addr(addr_l, fault_l), fault_l);
        rd2 <= rd1;
        rd3 <= rd2;
    end
    assign out_m = rd_m;
    assign out_l = rd3;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic score(input string tag, input exp_t e, input int err, input int fa,
                         input int ps, input int disp, input int bc, input int ac, input int both);
        check({tag, "_err_count"}, err, e.err);
        check({tag, "_fail_addr"}, fa, e.fa);
        check({tag, "_pass"}, ps, e.pass);
        check({tag, "_disp_val"}, disp, e.disp);
        check({tag, "_busy_cycles"}, bc, e.busy);
        check({tag, "_access_cycles"}, ac, e.acc);
        check({tag, "_get_and_set"}, both, 0);
    endtask

    function automatic exp_t mk(input int err, input int fa, input int ps, input int disp,
                                input int bc, input int ac);
        exp_t e;
        e.err = err; e.fa = fa; e.pass = ps; e.disp = disp; e.busy = bc; e.acc = ac;
        return e;
    endfunction

    initial begin : mon_main
        int bc, ac, both;
        logic dp;
        exp_t e;
        bc = 0; ac = 0; both = 0; dp = 1'b0;
        forever begin
            @(negedge mclk);
            if (rst) begin
                bc = 0; ac = 0; both = 0; dp = 1'b0;
            end else begin
                if (busy_m) bc++;
                if (get_m || set_m) ac++;
                if (get_m && set_m) both++;
                if (done_m && !dp) begin
                    check("main_result_expected", int'(q_m.size() > 0), 1);
                    if (q_m.size() > 0) begin
                        e = q_m.pop_front();
                        score("main", e, int'(err_m), int'(fa_m), int'(pass_m), int'(disp_m),
                              bc, ac, both);
                    end
                    bc = 0; ac = 0; both = 0;
                end
                dp = done_m;
            end
        end
    end

    initial begin : mon_lat
        int bc, ac, both;
        logic dp;
        exp_t e;
        bc = 0; ac = 0; both = 0; dp = 1'b0;
        forever begin
            @(negedge mclk);
            if (rst) begin
                bc = 0; ac = 0; both = 0; dp = 1'b0;
            end else begin
                if (busy_l) bc++;
                if (get_l || set_l) ac++;
                if (get_l && set_l) both++;
                if (done_l && !dp) begin
                    check("lat_result_expected", int'(q_l.size() > 0), 1);
                    if (q_l.size() > 0) begin
                        e = q_l.pop_front();
                        score("lat", e, int'(err_l), int'(fa_l), int'(pass_l), int'(disp_l),
                              bc, ac, both);
                    end
                    bc = 0; ac = 0; both = 0;
                end
                dp = done_l;
            end
        end
    end

    task automatic run(input int which, input exp_t e, input int hold);
        logic d;
        if (which == 0) q_m.push_back(e);
        else            q_l.push_back(e);
        @(negedge mclk);
        if (which == 0) start_m = 1'b1;
        else            start_l = 1'b1;
        repeat (hold) @(negedge mclk);
        start_m = 1'b0;
        start_l = 1'b0;
        d = 1'b0;
        for (int i = 0; i < 300 && !d; i++) begin
            @(negedge mclk);
            d = (which == 0) ? done_m : done_l;
        end
        check((which == 0) ? "main_done_seen" : "lat_done_seen", int'(d), 1);
        repeat (2) @(negedge mclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge mclk);
        check("reset_main_zero", int'(|{addr_m, val_m, get_m, set_m, busy_m, done_m, pass_m,
                                       err_m, fa_m, disp_m}), 0);
        check("reset_lat_zero", int'(|{addr_l, val_l, get_l, set_l, busy_l, done_l, pass_l,
                                      err_l, fa_l, disp_l}), 0);
        rst = 1'b0;

        fault_m = 0;
        run(0, mk(0, 0, 1, 0, 33, 32), 1);
        fault_m = 1;
        run(0, mk(StuckErr, 3, 0, StuckDisp, StuckBusy, StuckAcc), 1);
        fault_m = 2;
        run(0, mk(AliasErr, 0, 0, AliasDisp, AliasBusy, AliasAcc), 1);
        fault_m = 0;
        run(0, mk(0, 0, 1, 0, 33, 32), 20);

        // Abort a run partway through with reset, then confirm a clean rerun.
        @(negedge mclk);
        start_m = 1'b1;
        @(negedge mclk);
        start_m = 1'b0;
        repeat (9) @(negedge mclk);
        check("busy_before_reset", int'(busy_m), 1);
        rst = 1'b1;
        #1;
        check("reset_mid_run_zero", int'(|{addr_m, val_m, get_m, set_m, busy_m, done_m, pass_m,
                                          err_m, fa_m, disp_m}), 0);
        repeat (2) @(negedge mclk);
        rst = 1'b0;
        run(0, mk(0, 0, 1, 0, 33, 32), 1);

        fault_l = 0;
        run(1, mk(0, 0, 1, 0, 67, 64), 1);
        fault_l = 2;
        run(1, mk(LatErr, 0, 0, LatDisp, LatBusy, LatAcc), 1);

        check("main_queue_drained", q_m.size(), 0);
        check("lat_queue_drained", q_l.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
